bcd_seq_adder: RTL and testbench

- Multi-digit packed-BCD add/subtract sequencer built around one shared instance of the team's 2-digit (8-bit) BCD adder, BCD8.
- Accepts two NBYTES-byte packed-BCD operands and walks them through BCD8 one byte per clock, LSB byte first, chaining the decimal carry.
- Returns the sum or difference with a ready/valid handshake.
- Sits between the command front-end and the result register file of the decimal datapath.

---
 rtl/bcd_seq_adder.sv | 126 ++++++++++++
 tb/tb_bcd_seq_adder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bcd_seq_adder.sv
// Multi-byte packed-BCD add/subtract sequencer: steps one shared 2-digit BCD
// adder across the operands LSB byte first, chaining the decimal carry.

module bcd8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [4:0] lo_raw, hi_raw;
  logic       c1;

  always_comb begin
    lo_raw  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
    c1      = (lo_raw > 5'd9);
    s[3:0]  = lo_raw[3:0] + (c1 ? 4'd6 : 4'd0);
    hi_raw  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c1};
    co      = (hi_raw > 5'd9);
    s[7:4]  = hi_raw[3:0] + (co ? 4'd6 : 4'd0);
  end
endmodule

module bcd_seq_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  op_sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  err,
  output logic                  busy
);
  localparam int IW = $clog2(NBYTES) + 1;
  localparam int SW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            idx;
  logic [SW-1:0]            sel;
  logic                     carry, sub_q, bad, last;
  logic [NBYTES-1:0][7:0]   a_q, b_q, res_q;
  logic [7:0]               b_op, sum;
  logic                     sum_co;

  assign sel  = idx[SW-1:0];
  assign last = (idx == IW'(NBYTES - 1));

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < 2*NBYTES; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  // Subtraction is A + nine's-complement(B) + 1; digits are already known valid.
  always_comb begin
    b_op = b_q[sel];
    if (sub_q) b_op = {4'd9 - b_q[sel][7:4], 4'd9 - b_q[sel][3:0]};
  end

  bcd8 u_bcd8 (.a(a_q[sel]), .b(b_op), .ci(carry), .s(sum), .co(sum_co));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = bad ? DONE : RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (res_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state == IDLE);
    res_valid   = (state == DONE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_q   <= a;
          b_q   <= b;
          sub_q <= op_sub;
          carry <= op_sub ? 1'b1 : cin;
          idx   <= '0;
          res_q <= '0;
          cout  <= 1'b0;
          err   <= bad;
        end
        RUN: begin
          res_q[sel] <= sum;
          carry      <= sum_co;
          idx        <= idx + 1'b1;
          if (last) cout <= sum_co;
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;
endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed bench: NBYTES=2 instance for arithmetic/handshake, NBYTES=4 for reset abort.

module tb_bcd_seq_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sv2 = 0, sr2, sub2 = 0, ci2 = 0, rv2, rr2 = 0, co2, er2, bz2;
  logic [15:0] a2 = 0, b2 = 0, r2;
  logic        sv4 = 0, sr4, sub4 = 0, ci4 = 0, rv4, rr4 = 0, co4, er4, bz4;
  logic [31:0] a4 = 0, b4 = 0, r4;

  int n_chk = 0;
  int n_fail = 0;

  bcd_seq_adder #(.NBYTES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
    .op_sub(sub2), .cin(ci2), .a(a2), .b(b2), .res_valid(rv2),
    .res_ready(rr2), .result(r2), .cout(co2), .err(er2), .busy(bz2));

  bcd_seq_adder #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .op_sub(sub4), .cin(ci4), .a(a4), .b(b4), .res_valid(rv4),
    .res_ready(rr4), .result(r4), .cout(co4), .err(er4), .busy(bz4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic wait2(input string tag, input int exp_lat);
    int lat = 1;
    while (!rv2 && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic accept2(input logic [15:0] av, input logic [15:0] bv, input logic s, input logic c);
    a2 = av; b2 = bv; sub2 = s; ci2 = c; sv2 = 1'b1;
    @(posedge clk); #1;
    sv2 = 1'b0;
  endtask

  task automatic run2(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic s, input logic c, input logic [15:0] er,
                      input logic ec, input logic ee, input int lat);
    accept2(av, bv, s, c);
    wait2(tag, lat);
    check({tag, "_res"},  64'(r2),  64'(er));
    check({tag, "_cout"}, 64'(co2), 64'(ec));
    check({tag, "_err"},  64'(er2), 64'(ee));
    rr2 = 1'b1; @(posedge clk); #1; rr2 = 1'b0;
    check({tag, "_rv_drop"}, 64'(rv2), 64'd0);
    check({tag, "_idle"},    64'(sr2), 64'd1);
  endtask

  initial begin
    #2;
    check("rst_res",   64'(r2),  64'd0);
    check("rst_cout",  64'(co2), 64'd0);
    check("rst_err",   64'(er2), 64'd0);
    check("rst_rv",    64'(rv2), 64'd0);
    check("rst_busy",  64'(bz2), 64'd0);
    check("rst_ready", 64'(sr2), 64'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run2("add45_55",  16'h0045, 16'h0055, 0, 0, 16'h0100, 0, 0, 3);
    run2("add_wrap",  16'h9999, 16'h0001, 0, 0, 16'h0000, 1, 0, 3);
    run2("add_cin",   16'h9999, 16'h0000, 0, 1, 16'h0000, 1, 0, 3);
    run2("sub_borrow",16'h0100, 16'h0001, 1, 0, 16'h0099, 1, 0, 3);
    run2("sub_neg",   16'h0001, 16'h0002, 1, 0, 16'h9999, 0, 0, 3);
    run2("sub_eq",    16'h4321, 16'h4321, 1, 0, 16'h0000, 1, 0, 3);
    run2("sub_cin_ig",16'h0050, 16'h0020, 1, 1, 16'h0030, 1, 0, 3);
    run2("err_a",     16'h00A1, 16'h0002, 0, 0, 16'h0000, 0, 1, 1);
    run2("err_b",     16'h0012, 16'h0F00, 1, 0, 16'h0000, 0, 1, 1);

    // Backpressure: pending request with new operands must not be taken while DONE.
    accept2(16'h0045, 16'h0055, 0, 0);
    a2 = 16'h0012; b2 = 16'h0034; sub2 = 0; ci2 = 0; sv2 = 1'b1;
    wait2("bp", 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_res",   64'(r2),  64'h0100);
      check("bp_ready", 64'(sr2), 64'd0);
      check("bp_rv",    64'(rv2), 64'd1);
      @(posedge clk); #1;
    end
    rr2 = 1'b1; @(posedge clk); #1; rr2 = 1'b0;
    check("bp_idle_ready", 64'(sr2), 64'd1);
    check("bp_idle_rv",    64'(rv2), 64'd0);
    @(posedge clk); #1; sv2 = 1'b0;
    check("bp_accept_busy", 64'(bz2), 64'd1);
    begin
      int lat = 1;
      while (!rv2 && lat < 20) begin @(posedge clk); #1; lat++; end
      check("bp2_lat", 64'(lat), 64'd3);
    end
    check("bp2_res",  64'(r2),  64'h0046);
    check("bp2_cout", 64'(co2), 64'd0);
    rr2 = 1'b1; @(posedge clk); #1; rr2 = 1'b0;

    // Reset abort on the 2nd RUN cycle of the 4-byte instance.
    a4 = 32'h11111111; b4 = 32'h22222222; sv4 = 1'b1;
    @(posedge clk); #1; sv4 = 1'b0;
    check("r4_run1_busy", 64'(bz4), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("r4_rst_res",   64'(r4),  64'd0);
    check("r4_rst_busy",  64'(bz4), 64'd0);
    check("r4_rst_rv",    64'(rv4), 64'd0);
    check("r4_rst_ready", 64'(sr4), 64'd1);
    check("r4_rst_cout",  64'(co4), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    a4 = 32'h12345678; b4 = 32'h87654321; sv4 = 1'b1;
    @(posedge clk); #1; sv4 = 1'b0;
    a4 = 32'h0; b4 = 32'h0;
    begin
      int lat = 1;
      while (!rv4 && lat < 20) begin @(posedge clk); #1; lat++; end
      check("r4_lat", 64'(lat), 64'd5);
    end
    check("r4_res",  64'(r4),  64'h99999999);
    check("r4_cout", 64'(co4), 64'd0);
    check("r4_err",  64'(er4), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
